ub_read_scheduler: RTL and testbench

Arbitrates unified-buffer read bursts between two requesters, requester 0 (weight loader) and requester 1 (input/activation loader). It validates each request, then issues a one-cycle read command (start, address, length, row/col) to the unified buffer. It holds off further commands until the buffer's staggered read burst has fully drained. It sits between the loaders/instruction decoder and the unified buffer read-control inputs; unified-buffer writes are not touched.

---
 rtl/ub_read_scheduler.sv | 137 +++++++++++++
 tb/tb_ub_read_scheduler.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ub_read_scheduler.sv
// Unified-buffer read scheduler: round-robin arbitration between two loaders,
// request validation, and a one-cycle start followed by a burst drain window.
module ub_read_scheduler #(
  parameter int UB_DEPTH = 50,
  parameter int ADDR_W   = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_0,
  input  logic [ADDR_W-1:0] req_addr_0,
  input  logic [ADDR_W-1:0] req_len_0,
  input  logic              req_row_or_col_0,
  output logic              req_ready_0,
  input  logic              req_valid_1,
  input  logic [ADDR_W-1:0] req_addr_1,
  input  logic [ADDR_W-1:0] req_len_1,
  input  logic              req_row_or_col_1,
  output logic              req_ready_1,
  output logic              ub_read_start_out,
  output logic [ADDR_W-1:0] ub_read_addr_out,
  output logic [ADDR_W-1:0] ub_num_mem_locations_out,
  output logic              ub_row_or_col_out,
  output logic              grant_id_out,
  output logic              busy_out,
  output logic              done_out,
  output logic              err_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [ADDR_W:0]   UB_LIMIT = UB_DEPTH[ADDR_W:0];
  localparam logic [ADDR_W-1:0] CNT_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state, next_state;
  logic              last_grant;
  logic              grant;
  logic              grant_vld;
  logic [ADDR_W-1:0] sel_addr;
  logic [ADDR_W-1:0] sel_len;
  logic              sel_roc;
  logic [ADDR_W:0]   end_addr;
  logic              req_ok;
  logic [ADDR_W-1:0] drain_cnt;

  // Arbitration and request validation; only evaluated while IDLE.
  always_comb begin
    grant_vld = 1'b0;
    grant     = 1'b0;
    if (state == IDLE) begin
      if (req_valid_0 && req_valid_1) begin
        grant_vld = 1'b1;
        grant     = ~last_grant;
      end else if (req_valid_0) begin
        grant_vld = 1'b1;
        grant     = 1'b0;
      end else if (req_valid_1) begin
        grant_vld = 1'b1;
        grant     = 1'b1;
      end else begin
        grant_vld = 1'b0;
      end
    end else begin
      grant_vld = 1'b0;
    end
    sel_addr = grant ? req_addr_1 : req_addr_0;
    sel_len  = grant ? req_len_1 : req_len_0;
    sel_roc  = grant ? req_row_or_col_1 : req_row_or_col_0;
    // Extra bit keeps addr+len from wrapping past the buffer end.
    end_addr = {1'b0, sel_addr} + {1'b0, sel_len};
    req_ok   = (sel_len != '0) && !sel_len[0] && (end_addr <= UB_LIMIT);
  end

  assign req_ready_0       = grant_vld && !grant;
  assign req_ready_1       = grant_vld && grant;
  assign ub_read_start_out = (state == ISSUE);
  assign busy_out          = (state != IDLE);

  // Next-state decode.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (grant_vld && req_ok) begin
          next_state = ISSUE;
        end else begin
          next_state = IDLE;
        end
      end
      ISSUE: next_state = DRAIN;
      DRAIN: begin
        if (drain_cnt == CNT_ONE) begin
          next_state = IDLE;
        end else begin
          next_state = DRAIN;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State, arbitration history, drain counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                    <= IDLE;
      last_grant               <= 1'b1;
      drain_cnt                <= '0;
      ub_read_addr_out         <= '0;
      ub_num_mem_locations_out <= '0;
      ub_row_or_col_out        <= 1'b0;
      grant_id_out             <= 1'b0;
      done_out                 <= 1'b0;
      err_out                  <= 1'b0;
    end else begin
      state    <= next_state;
      done_out <= (state == DRAIN) && (next_state == IDLE);
      err_out  <= grant_vld && !req_ok;
      if (grant_vld) begin
        ub_read_addr_out         <= sel_addr;
        ub_num_mem_locations_out <= sel_len;
        ub_row_or_col_out        <= sel_roc;
        grant_id_out             <= grant;
        last_grant               <= grant;
      end
      // The drain window mirrors the buffer's len/2 active read cycles.
      if (state == ISSUE) begin
        drain_cnt <= ub_num_mem_locations_out >> 1;
      end else if (state == DRAIN) begin
        drain_cnt <= drain_cnt - CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_ub_read_scheduler.sv
// Scoreboard bench for ub_read_scheduler: a cycle-timeline reference model
// predicts starts, dones and errors; a monitor pops and compares them.
module tb_ub_read_scheduler;
  localparam int AW    = 6;
  localparam int DEPTH = 50;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid_0, req_row_or_col_0, req_ready_0;
  logic [AW-1:0] req_addr_0, req_len_0;
  logic          req_valid_1, req_row_or_col_1, req_ready_1;
  logic [AW-1:0] req_addr_1, req_len_1;
  logic          ub_read_start_out, ub_row_or_col_out, grant_id_out;
  logic [AW-1:0] ub_read_addr_out, ub_num_mem_locations_out;
  logic          busy_out, done_out, err_out;

  ub_read_scheduler #(.UB_DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid_0(req_valid_0), .req_addr_0(req_addr_0), .req_len_0(req_len_0),
    .req_row_or_col_0(req_row_or_col_0), .req_ready_0(req_ready_0),
    .req_valid_1(req_valid_1), .req_addr_1(req_addr_1), .req_len_1(req_len_1),
    .req_row_or_col_1(req_row_or_col_1), .req_ready_1(req_ready_1),
    .ub_read_start_out(ub_read_start_out), .ub_read_addr_out(ub_read_addr_out),
    .ub_num_mem_locations_out(ub_num_mem_locations_out),
    .ub_row_or_col_out(ub_row_or_col_out), .grant_id_out(grant_id_out),
    .busy_out(busy_out), .done_out(done_out), .err_out(err_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int c; int addr; int len; int roc; int gid;} start_t;
  typedef struct {int addr; int len; int roc;} req_t;

  start_t start_q[$];
  int     done_q[$];
  int     err_q[$];
  req_t   rq0[$], rq1[$];

  int   n_cmp = 0;
  int   n_bad = 0;
  int   free_c = 0;     // first cycle at which the scheduler is idle again
  int   lg = 1;         // requester that won most recently
  logic rnd_gaps = 1'b0;
  logic rdy0_s, rdy1_s;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: who is granted this cycle, and what that implies later.
  task automatic model_eval();
    int c, g, a, l, r;
    bit idle, ok;
    c = cyc;
    idle = (c >= free_c);
    check("busy", int'(busy_out), int'(!idle));
    g = -1;
    if (idle) begin
      if (req_valid_0 && req_valid_1) g = 1 - lg;
      else if (req_valid_0) g = 0;
      else if (req_valid_1) g = 1;
    end
    check("ready0", int'(req_ready_0), int'(g == 0));
    check("ready1", int'(req_ready_1), int'(g == 1));
    if (g >= 0) begin
      lg = g;
      a = (g == 1) ? int'(req_addr_1) : int'(req_addr_0);
      l = (g == 1) ? int'(req_len_1) : int'(req_len_0);
      r = (g == 1) ? int'(req_row_or_col_1) : int'(req_row_or_col_0);
      ok = (l != 0) && (l % 2 == 0) && (a + l <= DEPTH);
      if (ok) begin
        start_q.push_back('{c + 1, a, l, r, g});
        done_q.push_back(c + 2 + l / 2);
        free_c = c + 2 + l / 2;
      end else begin
        err_q.push_back(c + 1);
      end
    end
  endtask

  task automatic drive();
    req_t r;
    if (rdy0_s) req_valid_0 = 1'b0;
    if (rdy1_s) req_valid_1 = 1'b0;
    if (!req_valid_0 && rq0.size() > 0 && (!rnd_gaps || $urandom_range(0, 2) != 0)) begin
      r = rq0.pop_front();
      req_valid_0 = 1'b1; req_addr_0 = AW'(r.addr); req_len_0 = AW'(r.len);
      req_row_or_col_0 = r.roc[0];
    end
    if (!req_valid_1 && rq1.size() > 0 && (!rnd_gaps || $urandom_range(0, 2) != 0)) begin
      r = rq1.pop_front();
      req_valid_1 = 1'b1; req_addr_1 = AW'(r.addr); req_len_1 = AW'(r.len);
      req_row_or_col_1 = r.roc[0];
    end
    rdy0_s = 1'b0;
    rdy1_s = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
    model_eval();
    rdy0_s = req_ready_0;
    rdy1_s = req_ready_1;
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic run_quiet(input int budget);
    int n;
    n = 0;
    while (!(rq0.size() == 0 && rq1.size() == 0 && !req_valid_0 && !req_valid_1
             && cyc > free_c + 1) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) check("quiet_timeout", 1, 0);
    repeat (2) step();
  endtask

  // Monitor: every start/done/err the DUT presents must match the next prediction.
  always @(negedge clk) begin
    if (!rst) begin
      if (ub_read_start_out) begin
        if (start_q.size() == 0) check("start_unexpected", 1, 0);
        else begin
          start_t s;
          s = start_q.pop_front();
          check("start_cycle", cyc, s.c);
          check("start_addr", int'(ub_read_addr_out), s.addr);
          check("start_len", int'(ub_num_mem_locations_out), s.len);
          check("start_roc", int'(ub_row_or_col_out), s.roc);
          check("start_gid", int'(grant_id_out), s.gid);
        end
      end
      if (done_out) begin
        if (done_q.size() == 0) check("done_unexpected", 1, 0);
        else check("done_cycle", cyc, done_q.pop_front());
      end
      if (err_out) begin
        if (err_q.size() == 0) check("err_unexpected", 1, 0);
        else check("err_cycle", cyc, err_q.pop_front());
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_start"}, int'(ub_read_start_out), 0);
    check({tag, "_addr"}, int'(ub_read_addr_out), 0);
    check({tag, "_len"}, int'(ub_num_mem_locations_out), 0);
    check({tag, "_roc"}, int'(ub_row_or_col_out), 0);
    check({tag, "_gid"}, int'(grant_id_out), 0);
    check({tag, "_busy"}, int'(busy_out), 0);
    check({tag, "_done"}, int'(done_out), 0);
    check({tag, "_err"}, int'(err_out), 0);
    check({tag, "_ready0"}, int'(req_ready_0), 0);
    check({tag, "_ready1"}, int'(req_ready_1), 0);
  endtask

  initial begin
    int n, len;
    rst = 1'b1;
    req_valid_0 = 1'b0; req_addr_0 = '0; req_len_0 = '0; req_row_or_col_0 = 1'b0;
    req_valid_1 = 1'b0; req_addr_1 = '0; req_len_1 = '0; req_row_or_col_1 = 1'b0;
    rdy0_s = 1'b0; rdy1_s = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    free_c = 0; lg = 1;
    @(posedge clk); #1;

    // Contention straight out of reset: requester 0 first, then 1.
    rq0.push_back('{0, 4, 0}); rq1.push_back('{8, 4, 1}); drive();
    run_quiet(100);
    // Single request.
    rq0.push_back('{4, 6, 1}); drive();
    run_quiet(100);
    // Round robin with both requesters continuously valid.
    repeat (2) begin rq0.push_back('{0, 2, 0}); rq1.push_back('{10, 2, 1}); end
    drive();
    run_quiet(100);
    // Invalid lengths, overflow, and exact-fit boundary.
    rq0.push_back('{0, 5, 0}); rq0.push_back('{0, 0, 1});
    rq0.push_back('{46, 6, 0}); rq0.push_back('{44, 6, 1}); drive();
    run_quiet(100);
    // Back-to-back from one requester.
    repeat (4) rq0.push_back('{2, 2, 0});
    drive();
    run_quiet(100);

    // Reset in the middle of a long burst's drain.
    rq0.push_back('{0, 10, 0}); drive();
    n = 0;
    while (!(start_q.size() == 0 && cyc < free_c - 1 && busy_out) && n < 20) begin
      step(); n++;
    end
    if (n >= 20) check("burst_start_timeout", 1, 0);
    step(); step();
    rst = 1'b1;
    #1;
    check_all_zero("midreset");
    start_q.delete(); done_q.delete(); err_q.delete();
    free_c = 0; lg = 1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    rq0.push_back('{0, 4, 0}); rq1.push_back('{20, 4, 1}); drive();
    run_quiet(100);

    // Randomized traffic with random issue gaps.
    rnd_gaps = 1'b1;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0:       len = int'($urandom_range(0, 63));
        1:       len = 0;
        default: len = 2 * int'($urandom_range(1, 8));
      endcase
      if ($urandom_range(0, 1) == 0) rq0.push_back('{int'($urandom_range(0, 52)), len, int'($urandom_range(0, 1))});
      else rq1.push_back('{int'($urandom_range(0, 52)), len, int'($urandom_range(0, 1))});
    end
    run_quiet(20000);

    check("start_q_left", start_q.size(), 0);
    check("done_q_left", done_q.size(), 0);
    check("err_q_left", err_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
